// File: rtl/mem_arb.sv
// mem_arb: serialises I$ refills and D$ refills/write-throughs onto one memory port.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; default is fixed D$ priority.
module mem_arb #(
  parameter int ADDR_W = 28,
  parameter int BEATS  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_req_valid,
  input  logic [ADDR_W-1:0] ic_req_addr,
  output logic              ic_req_ready,
  output logic              ic_resp_valid,
  output logic [31:0]       ic_resp_data,
  output logic              ic_resp_last,
  input  logic              dc_req_valid,
  input  logic              dc_req_rnw,
  input  logic [ADDR_W-1:0] dc_req_addr,
  input  logic [31:0]       dc_req_wdata,
  input  logic [3:0]        dc_req_wmask,
  output logic              dc_req_ready,
  output logic              dc_resp_valid,
  output logic [31:0]       dc_resp_data,
  output logic              dc_resp_last,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_rnw,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [31:0]       mem_req_wdata,
  output logic [3:0]        mem_req_wmask,
  input  logic              mem_rdata_valid,
  input  logic [31:0]       mem_rdata,
  output logic              busy,
  output logic              owner,
  output logic              proto_err
);
  localparam int CW = $clog2(BEATS);
  typedef enum logic [1:0] {IDLE, ISSUE, RDATA} state_t;
  state_t state, nextState;
  logic [CW-1:0] beatCnt;
  logic anyValid, pickDc, accept, beat, lastBeat, grant;
  assign anyValid = ic_req_valid | dc_req_valid;
  assign grant = (state == IDLE) & anyValid;
`ifdef MEM_ARB_RR_EN
  // lastGrant: 0 = I$, 1 = D$; on a tie the other requester wins
  logic lastGrant;
  assign pickDc = dc_req_valid & (~ic_req_valid | ~lastGrant);
  always_ff @(posedge clk)
    if (reset) lastGrant <= 1'b0;
    else if (grant) lastGrant <= pickDc;
`else
  assign pickDc = dc_req_valid;
`endif
  assign mem_req_valid = state == ISSUE;
  assign accept = mem_req_valid & mem_req_ready;
  assign ic_req_ready = accept & ~owner;
  assign dc_req_ready = accept & owner;
  assign beat = (state == RDATA) & mem_rdata_valid;
  assign lastBeat = beat & (beatCnt == CW'(BEATS - 1));
  assign ic_resp_valid = beat & ~owner;
  assign dc_resp_valid = beat & owner;
  assign ic_resp_last = lastBeat & ~owner;
  assign dc_resp_last = lastBeat & owner;
  assign ic_resp_data = mem_rdata;
  assign dc_resp_data = mem_rdata;
  assign busy = state != IDLE;
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    nextState = anyValid ? ISSUE : IDLE;
      ISSUE:   nextState = accept ? (mem_req_rnw ? RDATA : IDLE) : ISSUE;
      RDATA:   nextState = lastBeat ? IDLE : RDATA;
      default: nextState = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      owner <= 1'b0;
      mem_req_rnw <= 1'b0;
      mem_req_addr <= '0;
      mem_req_wdata <= '0;
      mem_req_wmask <= '0;
      beatCnt <= '0;
      proto_err <= 1'b0;
    end else begin
      state <= nextState;
      if (grant) begin
        owner <= pickDc;
        mem_req_rnw <= pickDc ? dc_req_rnw : 1'b1;
        mem_req_addr <= pickDc ? dc_req_addr : ic_req_addr;
        mem_req_wdata <= pickDc ? dc_req_wdata : 32'h0;
        mem_req_wmask <= pickDc ? dc_req_wmask : 4'h0;
      end
      if (state == ISSUE) beatCnt <= '0;
      else if (beat) beatCnt <= beatCnt + 1'b1;
      if (mem_rdata_valid && state != RDATA) proto_err <= 1'b1;
    end
endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed self-checking bench for mem_arb (either arbitration build).
module tb_mem_arb;
  localparam int AW = 28;
  logic clk = 0, reset = 0;
  logic ic_req_valid = 0, ic_req_ready, ic_resp_valid, ic_resp_last;
  logic [AW-1:0] ic_req_addr = '0;
  logic [31:0] ic_resp_data;
  logic dc_req_valid = 0, dc_req_rnw = 0, dc_req_ready, dc_resp_valid, dc_resp_last;
  logic [AW-1:0] dc_req_addr = '0;
  logic [31:0] dc_req_wdata = '0, dc_resp_data;
  logic [3:0] dc_req_wmask = '0;
  logic mem_req_valid, mem_req_ready = 0, mem_req_rnw;
  logic [AW-1:0] mem_req_addr;
  logic [31:0] mem_req_wdata, mem_rdata = '0;
  logic [3:0] mem_req_wmask;
  logic mem_rdata_valid = 0, busy, owner, proto_err;
  int nTests = 0, nFail = 0;

  mem_arb #(.ADDR_W(AW), .BEATS(4)) dut (
    .clk(clk), .reset(reset),
    .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
    .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data), .ic_resp_last(ic_resp_last),
    .dc_req_valid(dc_req_valid), .dc_req_rnw(dc_req_rnw), .dc_req_addr(dc_req_addr),
    .dc_req_wdata(dc_req_wdata), .dc_req_wmask(dc_req_wmask), .dc_req_ready(dc_req_ready),
    .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data), .dc_resp_last(dc_resp_last),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rnw(mem_req_rnw),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  // inputs change 1ns after the edge, outputs are sampled 1ns later
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1;
    tick();
    reset = 0;
  endtask

  // entered in an IDLE cycle with the requester valid(s) already driven; returns in the next IDLE cycle
  task automatic run_read(input logic expOwner, input logic [AW-1:0] expAddr, input string name);
    logic [31:0] d;
    #1;
    nTests++;
    if (busy !== 1'b0) begin $display("FAIL %s idle: busy=%b want 0", name, busy); nFail++; end
    tick();
    mem_req_ready = 1;
    #1;
    nTests++;
    if ({mem_req_valid, mem_req_rnw, owner, mem_req_addr} !== {1'b1, 1'b1, expOwner, expAddr}) begin
      $display("FAIL %s issue: valid/rnw/owner/addr=%b/%b/%b/%h want 1/1/%b/%h", name, mem_req_valid,
               mem_req_rnw, owner, mem_req_addr, expOwner, expAddr);
      nFail++;
    end
    nTests++;
    if ({ic_req_ready, dc_req_ready} !== {~expOwner, expOwner}) begin
      $display("FAIL %s ready: ic/dc=%b/%b want %b/%b", name, ic_req_ready, dc_req_ready, ~expOwner, expOwner);
      nFail++;
    end
    tick();
    mem_req_ready = 0;
    for (int k = 0; k < 4; k++) begin
      d = {4'h0, expAddr} + 32'(k);
      mem_rdata_valid = 1;
      mem_rdata = d;
      #1;
      nTests++;
      if ({ic_resp_valid, dc_resp_valid} !== {~expOwner, expOwner} ||
          (expOwner ? dc_resp_data : ic_resp_data) !== d ||
          (expOwner ? dc_resp_last : ic_resp_last) !== (k == 3) ||
          (expOwner ? ic_resp_last : dc_resp_last) !== 1'b0) begin
        $display("FAIL %s beat%0d: icv/dcv=%b/%b data=%h last ic/dc=%b/%b want owner=%b data=%h last=%b",
                 name, k, ic_resp_valid, dc_resp_valid, expOwner ? dc_resp_data : ic_resp_data,
                 ic_resp_last, dc_resp_last, expOwner, d, k == 3);
        nFail++;
      end
      tick();
    end
    mem_rdata_valid = 0;
  endtask

  task automatic test_reset;
    do_reset();
    #1;
    nTests++;
    if ({busy, mem_req_valid, ic_req_ready, dc_req_ready, owner, proto_err} !== 6'b0) begin
      $display("FAIL reset ctl: busy/mv/icr/dcr/own/err=%b%b%b%b%b%b want 000000", busy, mem_req_valid,
               ic_req_ready, dc_req_ready, owner, proto_err);
      nFail++;
    end
    nTests++;
    if ({mem_req_rnw, mem_req_addr, mem_req_wdata, mem_req_wmask} !== '0 ||
        {ic_resp_valid, dc_resp_valid, ic_resp_last, dc_resp_last} !== 4'b0) begin
      $display("FAIL reset fields: rnw=%b addr=%h wdata=%h wmask=%h resp=%b%b%b%b want all 0", mem_req_rnw,
               mem_req_addr, mem_req_wdata, mem_req_wmask, ic_resp_valid, dc_resp_valid, ic_resp_last, dc_resp_last);
      nFail++;
    end
  endtask

  task automatic test_ic_read;
    logic [4:0] vld;
    logic [31:0] dat [5];
    int nBeats, nReady;
    vld = 5'b11011;
    dat = '{32'hA0, 32'hA1, 32'h0, 32'hA2, 32'hA3};
    nBeats = 0;
    nReady = 0;
    tick();
    ic_req_valid = 1;
    ic_req_addr = 28'h0000100;
    tick();
    mem_req_ready = 1;
    #1;
    nTests++;
    if ({mem_req_valid, ic_req_ready, dc_req_ready, mem_req_rnw, mem_req_wmask, owner} !== {4'b1101, 4'h0, 1'b0} ||
        mem_req_addr !== 28'h0000100) begin
      $display("FAIL ic_issue: mv/icr/dcr/rnw=%b%b%b%b wmask=%h own=%b addr=%h want 1101/0/0/0000100",
               mem_req_valid, ic_req_ready, dc_req_ready, mem_req_rnw, mem_req_wmask, owner, mem_req_addr);
      nFail++;
    end
    nReady += int'(ic_req_ready);
    tick();
    ic_req_valid = 0;
    mem_req_ready = 0;
    for (int i = 0; i < 5; i++) begin
      mem_rdata_valid = vld[4-i];
      mem_rdata = dat[i];
      #1;
      nReady += int'(ic_req_ready);
      nBeats += int'(ic_resp_valid);
      nTests++;
      if (ic_resp_valid !== vld[4-i] || dc_resp_valid !== 1'b0 || (vld[4-i] && ic_resp_data !== dat[i]) ||
          ic_resp_last !== (i == 4)) begin
        $display("FAIL ic_beat%0d: icv=%b dcv=%b data=%h last=%b want %b/0/%h/%b", i, ic_resp_valid,
                 dc_resp_valid, ic_resp_data, ic_resp_last, vld[4-i], dat[i], i == 4);
        nFail++;
      end
      tick();
    end
    mem_rdata_valid = 0;
    #1;
    nTests++;
    if (nBeats !== 4 || nReady !== 1 || busy !== 1'b0) begin
      $display("FAIL ic_done: beats=%0d readies=%0d busy=%b want 4/1/0", nBeats, nReady, busy);
      nFail++;
    end
  endtask

  task automatic test_dc_write;
    tick();
    dc_req_valid = 1;
    dc_req_rnw = 0;
    dc_req_addr = 28'h0000200;
    dc_req_wdata = 32'hDEADBEEF;
    dc_req_wmask = 4'b0011;
    tick();
    for (int i = 0; i < 4; i++) begin
      mem_req_ready = (i == 3);
      #1;
      nTests++;
      if ({mem_req_valid, mem_req_rnw, owner, dc_req_ready, ic_req_ready} !== {3'b101, i == 3, 1'b0} ||
          mem_req_addr !== 28'h0000200 || mem_req_wdata !== 32'hDEADBEEF || mem_req_wmask !== 4'b0011) begin
        $display("FAIL dc_wr_cyc%0d: mv/rnw/own/dcr/icr=%b%b%b%b%b addr=%h wd=%h wm=%b want 101%b0/200/DEADBEEF/0011",
                 i, mem_req_valid, mem_req_rnw, owner, dc_req_ready, ic_req_ready, mem_req_addr, mem_req_wdata,
                 mem_req_wmask, i == 3);
        nFail++;
      end
      tick();
    end
    dc_req_valid = 0;
    mem_req_ready = 0;
    #1;
    nTests++;
    if ({busy, mem_req_valid, dc_req_ready} !== 3'b0) begin
      $display("FAIL dc_wr_done: busy/mv/dcr=%b%b%b want 000", busy, mem_req_valid, dc_req_ready);
      nFail++;
    end
    tick();
    #1;
    nTests++;
    if (busy !== 1'b0) begin $display("FAIL dc_wr_idle: busy=%b want 0", busy); nFail++; end
  endtask

  // previous grant was the D$ write, so round-robin serves I$ first
  task automatic test_tie;
    logic first;
`ifdef MEM_ARB_RR_EN
    first = 0;
`else
    first = 1;
`endif
    tick();
    ic_req_valid = 1;
    ic_req_addr = 28'h0000300;
    dc_req_valid = 1;
    dc_req_rnw = 1;
    dc_req_addr = 28'h0000400;
    run_read(first, first ? 28'h0000400 : 28'h0000300, "tie_first");
    if (first) dc_req_valid = 0; else ic_req_valid = 0;
    run_read(~first, first ? 28'h0000300 : 28'h0000400, "tie_second");
    ic_req_valid = 0;
    dc_req_valid = 0;
    #1;
    nTests++;
    if (proto_err !== 1'b0) begin $display("FAIL tie_proto: proto_err=%b want 0", proto_err); nFail++; end
  endtask

  task automatic test_back_to_back;
    logic expOwner;
    do_reset();
    ic_req_valid = 1;
    ic_req_addr = 28'h0000500;
    dc_req_valid = 1;
    dc_req_rnw = 1;
    dc_req_addr = 28'h0000600;
    for (int t = 0; t < 4; t++) begin
`ifdef MEM_ARB_RR_EN
      expOwner = (t % 2 == 0);
`else
      expOwner = 1;
`endif
      run_read(expOwner, expOwner ? 28'h0000600 : 28'h0000500, $sformatf("b2b%0d", t));
    end
    ic_req_valid = 0;
    dc_req_valid = 0;
    tick();
  endtask

  task automatic test_proto_err;
    do_reset();
    mem_rdata_valid = 1;
    mem_rdata = 32'h55;
    #1;
    nTests++;
    if ({ic_resp_valid, dc_resp_valid, ic_resp_last, dc_resp_last} !== 4'b0) begin
      $display("FAIL proto_drop: icv/dcv/icl/dcl=%b%b%b%b want 0000", ic_resp_valid, dc_resp_valid,
               ic_resp_last, dc_resp_last);
      nFail++;
    end
    tick();
    mem_rdata_valid = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      nTests++;
      if (proto_err !== 1'b1) begin $display("FAIL proto_sticky%0d: proto_err=%b want 1", i, proto_err); nFail++; end
      tick();
    end
    do_reset();
    #1;
    nTests++;
    if (proto_err !== 1'b0) begin $display("FAIL proto_clear: proto_err=%b want 0", proto_err); nFail++; end
  endtask

  task automatic test_mid_reset;
    tick();
    ic_req_valid = 1;
    ic_req_addr = 28'h0000700;
    tick();
    mem_req_ready = 1;
    tick();
    ic_req_valid = 0;
    mem_req_ready = 0;
    for (int i = 0; i < 2; i++) begin
      mem_rdata_valid = 1;
      mem_rdata = 32'hB0 + 32'(i);
      tick();
    end
    reset = 1;
    mem_rdata = 32'hB2;
    tick();
    reset = 0;
    mem_rdata_valid = 0;
    #1;
    nTests++;
    if ({busy, mem_req_valid, ic_resp_valid, ic_resp_last, owner, proto_err} !== 6'b0 || mem_req_addr !== '0) begin
      $display("FAIL mid_reset: busy/mv/icv/icl/own/err=%b%b%b%b%b%b addr=%h want 000000/0", busy, mem_req_valid,
               ic_resp_valid, ic_resp_last, owner, proto_err, mem_req_addr);
      nFail++;
    end
    ic_req_valid = 1;
    ic_req_addr = 28'h0000800;
    run_read(1'b0, 28'h0000800, "post_reset");
    ic_req_valid = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_ic_read();
    test_dc_write();
    test_tie();
    test_back_to_back();
    test_proto_err();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule

// File: doc/mem_arb.md
# mem_arb

Two-requester memory arbiter that shares the single off-chip memory request port between the instruction cache (refill reads) and the data cache (refill reads and single-word write-through). It sits between the I$/D$ miss logic and the memory interface, serialises one transaction at a time, and routes read-return beats back to the owning cache. Pipeline stall logic consumes `busy` and the per-requester ready/last strobes.

## Interface
- `ADDR_W`, default 28: memory word address width.
- `BEATS`, default 4: 32-bit read beats per refill; power of two, 2–16.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `ic_req_valid` in 1: I$ refill request; held until `ic_req_ready`.
- `ic_req_addr` in ADDR_W: I$ line base address; stable while valid.
- `ic_req_ready` out 1: one-cycle pulse when memory accepts the I$ request.
- `ic_resp_valid` out 1: I$ read beat valid.
- `ic_resp_data` out 32: I$ read beat data.
- `ic_resp_last` out 1: final I$ beat.
- `dc_req_valid` in 1: D$ request; held until `dc_req_ready`.
- `dc_req_rnw` in 1: 1 = line read, 0 = single-word write.
- `dc_req_addr` in ADDR_W: D$ address.
- `dc_req_wdata` in 32: write data.
- `dc_req_wmask` in 4: byte write enables.
- `dc_req_ready` out 1: one-cycle pulse on acceptance.
- `dc_resp_valid`, `dc_resp_data` [32], `dc_resp_last` out: D$ read beats, same meaning as I$.
- `mem_req_valid` out 1: request to memory.
- `mem_req_ready` in 1: memory accepts when valid && ready.
- `mem_req_rnw`, `mem_req_addr` [ADDR_W], `mem_req_wdata` [32], `mem_req_wmask` [4] out: registered request fields.
- `mem_rdata_valid` in 1, `mem_rdata` in 32: read return beats, in order.
- `busy` out 1: FSM not IDLE.
- `owner` out 1: 0 = I$, 1 = D$; current/last grant.
- `proto_err` out 1: sticky; unexpected read beat.

## Operation
- FSM states: IDLE, ISSUE, RDATA.
- IDLE: if any `*_req_valid`, select a winner, register its fields into the `mem_req_*` registers, set `owner`, and go to ISSUE. I$ requests force `mem_req_rnw`=1 and `wmask`=0.
- ISSUE: assert `mem_req_valid`. Fields hold constant. On `mem_req_ready`, pulse the owner's `*_req_ready` in that same cycle. Next state: for a write, IDLE; for a read, RDATA with the beat counter cleared.
- RDATA: each `mem_rdata_valid` beat is forwarded to the owner only. Resp data is combinational from `mem_rdata`, and the valid is gated by `owner`. On beat BEATS-1, assert `*_resp_last` and go to IDLE. The counter is `$clog2(BEATS)` bits and wraps to 0.
- Arbitration without the macro: fixed priority, D$ over I$.
- The losing requester stays pending and is granted on the next IDLE visit.
- `mem_rdata_valid` in IDLE or ISSUE: the beat is dropped and `proto_err` is set until reset.
- Requester deasserting valid before ready is illegal. The latched request completes regardless.

## Timing
- Reset values: state IDLE; `mem_req_valid`, all `*_req_ready`, `*_resp_valid`, `*_resp_last`, `busy`, and `proto_err` are 0; `owner` 0; `mem_req_*` fields 0; beat count 0.
- Reset mid-transaction returns to IDLE next cycle. Outstanding beats after reset set `proto_err` (expected; the bench masks this).
- Request valid at edge N (IDLE) gives `mem_req_valid` at N+1. Minimum write occupancy is 2 cycles. Minimum read occupancy is 2 + BEATS cycles.
- Back-to-back: IDLE is always visited for exactly one cycle between transactions.
- Read beats may arrive with gaps, and the first beat may arrive in the cycle after acceptance.
- `*_req_ready` is never asserted for a requester that is not the owner.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin. When both requesters are valid in IDLE, grant the one not granted last. The last-grant register resets to I$, so D$ wins the first tie. With a single requester, grant it and update last-grant.
- Undefined: fixed D$ priority; no last-grant register is synthesised.

## Test plan
- Solo I$ read at addr 0x0000100, memory returns 0xA0..0xA3 with a 1-cycle gap after beat 1 -> `ic_req_ready` pulses once; 4 `ic_resp_valid` beats with matching data; `ic_resp_last` on 0xA3; `dc_resp_valid` stays 0.
- D$ write addr 0x0000200, data 0xDEADBEEF, mask 4'b0011, with `mem_req_ready` low 3 cycles -> `mem_req_*` stable for all 4 cycles; `dc_req_ready` pulses in the accept cycle; back to IDLE; `busy` low next cycle.
- I$ and D$ read valid in the same cycle, fixed priority -> D$ served first, then I$ after one IDLE cycle. With `MEM_ARB_RR_EN` and a prior D$ grant -> I$ first.
- D$ continuously valid with I$ also valid, `MEM_ARB_RR_EN` -> grants alternate D,I,D,I over 4 transactions. Without the macro, I$ starves while D$ stays valid.
- `mem_rdata_valid` pulse in IDLE -> no resp valid to either cache; `proto_err` = 1 and stays 1 until `reset`.
- `reset` asserted during RDATA beat 2 -> next cycle all outputs at reset values; a new I$ request is serviced normally afterwards.
